// File: rtl/debounce_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Purpose  : Shared types and constants for the debounce / button-event
//            path.
//            - One-hot state-index convention shared with the debounce FSM:
//              bit 0 is always the rest (idle) state, and further states take
//              the following bits in order.
//            - One-hot state type for button_event, with bit-index
//              localparams so that logic can test single bits.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Common one-hot index convention: the rest state always owns bit 0.
    localparam int unsigned ST_IDLE_BIT = 0;

    // button_event state indices
    localparam int unsigned BE_SHORT_BIT  = 1;
    localparam int unsigned BE_LONG_BIT   = 2;
    localparam int unsigned BE_NUM_STATES = 3;

    typedef enum logic [BE_NUM_STATES-1:0] {
        BE_IDLE  = 3'b001,   // bit ST_IDLE_BIT
        BE_SHORT = 3'b010,   // bit BE_SHORT_BIT
        BE_LONG  = 3'b100    // bit BE_LONG_BIT
    } be_state_e;

    // True when exactly one state bit is set.
    function automatic logic be_state_legal(input logic [BE_NUM_STATES-1:0] s);
        return $onehot(s);
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/button_event_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : button_event_if
// Purpose  : Signal bundle between the debounce stage / register logic and
//            button_event.
// Ports    : (interface signals)
//            db          - debounced switch level             (to block)
//            m_tick      - one-clk millisecond strobe          (to block)
//            clr_count   - synchronous clear of press_count    (to block)
//            press       - one-clk pulse on db rising          (from block)
//            release_ev  - one-clk pulse on db falling         (from block)
//            long_press  - one-clk pulse at LONG_TICKS of hold (from block)
//            repeat_ev   - one-clk auto-repeat pulse           (from block)
//            held        - level, high while a press is active (from block)
//            press_count - wrapping press counter, CNT_W bits  (from block)
//            "release" and "repeat" are language keywords, hence the _ev
//            suffix on those two pulses.
// Revision : 1.0 - initial release
// ============================================================================
interface button_event_if #(
    parameter int CNT_W = 8
) ();

    logic             db;
    logic             m_tick;
    logic             clr_count;
    logic             press;
    logic             release_ev;
    logic             long_press;
    logic             repeat_ev;
    logic             held;
    logic [CNT_W-1:0] press_count;

    // master: the side that supplies db/m_tick and consumes events
    modport master (
        output db, m_tick, clr_count,
        input  press, release_ev, long_press, repeat_ev, held, press_count
    );

    // slave: button_event itself
    modport slave (
        input  db, m_tick, clr_count,
        output press, release_ev, long_press, repeat_ev, held, press_count
    );

endinterface : button_event_if
`default_nettype wire

// File: rtl/button_event_edge_detect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : edge_detect
// Purpose  : Registers a synchronous level once and flags its rising and
//            falling edges combinationally against the registered copy.
//            Usable for any already-synchronised, debounced input.
// Ports    : clk   - system clock
//            reset - asynchronous active-high reset (clears d_q to 0)
//            d     - level input, synchronous to clk
//            rise  - d & ~d_q
//            fall  - ~d & d_q
// Revision : 1.0 - initial release
// ============================================================================
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_d;
    logic d_q;

    always_comb begin
        d_d = d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule : edge_detect
`default_nettype wire

// File: rtl/button_event.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : button_event
// Purpose  : Turns the debounced button level into single-cycle press,
//            release, long-press and auto-repeat events, plus a wrapping
//            press counter. Hold time is measured in m_tick strobes.
//            All outputs are registered: an event sampled at edge k is
//            visible in the cycle after edge k.
// Ports    : clk   - system clock
//            reset - asynchronous active-high reset
//            bus   - button_event_if.slave (db, m_tick, clr_count in;
//                    press, release_ev, long_press, repeat_ev, held,
//                    press_count out)
// Params   : LONG_TICKS   - ticks of hold before long_press (>= 1)
//            REPEAT_TICKS - ticks between repeats in long hold (0 = off)
//            CNT_W        - press_count width (must match the interface)
// Revision : 1.0 - initial release
// ============================================================================
module button_event
    import debounce_pkg::*;
#(
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    parameter int CNT_W        = 8
) (
    input  logic           clk,
    input  logic           reset,
    button_event_if.slave  bus
);

    localparam int HOLD_W = $clog2(LONG_TICKS + 1);
    localparam int REP_W  = (REPEAT_TICKS == 0) ? 1 : $clog2(REPEAT_TICKS + 1);
    localparam bit REP_EN = (REPEAT_TICKS != 0);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
    // With repeat disabled the terminal value is never compared against.
    localparam logic [REP_W-1:0]  REP_LAST  =
        REP_W'((REPEAT_TICKS == 0) ? 0 : (REPEAT_TICKS - 1));

    logic rise;
    logic fall;

    be_state_e        state_d,       state_q;
    logic [HOLD_W-1:0] hold_cnt_d,   hold_cnt_q;
    logic [REP_W-1:0]  rep_cnt_d,    rep_cnt_q;
    logic              press_d,      press_q;
    logic              release_d,    release_q;
    logic              long_press_d, long_press_q;
    logic              repeat_d,     repeat_q;
    logic              held_d,       held_q;
    logic [CNT_W-1:0]  press_count_d, press_count_q;

    edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .d     (bus.db),
        .rise  (rise),
        .fall  (fall)
    );

    // ------------------------------------------------------------------
    // Next state, counters and pulse outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        rep_cnt_d    = rep_cnt_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        long_press_d = 1'b0;
        repeat_d     = 1'b0;

        case (state_q)
            BE_IDLE: begin
                // A tick coinciding with the rise is deliberately not counted.
                if (rise) begin
                    state_d    = BE_SHORT;
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                end
            end

            BE_SHORT: begin
                // fall has priority over a simultaneous tick
                if (fall) begin
                    state_d   = BE_IDLE;
                    release_d = 1'b1;
                end else if (bus.m_tick) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d      = BE_LONG;
                        long_press_d = 1'b1;
                        rep_cnt_d    = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end

            BE_LONG: begin
                if (fall) begin
                    state_d   = BE_IDLE;
                    release_d = 1'b1;
                end else if (REP_EN && bus.m_tick) begin
                    if (rep_cnt_q == REP_LAST) begin
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
            end

            // Any non-one-hot encoding recovers silently to IDLE.
            default: begin
                state_d    = BE_IDLE;
                hold_cnt_d = '0;
                rep_cnt_d  = '0;
            end
        endcase

        held_d = (state_d != BE_IDLE);

        // Clear wins over increment, but a press on the clearing edge is
        // still counted so it is not lost.
        if (bus.clr_count) begin
            press_count_d = press_d ? CNT_W'(1) : '0;
        end else if (press_d) begin
            press_count_d = press_count_q + 1'b1;
        end else begin
            press_count_d = press_count_q;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BE_IDLE;
            hold_cnt_q    <= '0;
            rep_cnt_q     <= '0;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            long_press_q  <= 1'b0;
            repeat_q      <= 1'b0;
            held_q        <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            press_q       <= press_d;
            release_q     <= release_d;
            long_press_q  <= long_press_d;
            repeat_q      <= repeat_d;
            held_q        <= held_d;
            press_count_q <= press_count_d;
        end
    end

    assign bus.press       = press_q;
    assign bus.release_ev  = release_q;
    assign bus.long_press  = long_press_q;
    assign bus.repeat_ev   = repeat_q;
    assign bus.held        = held_q;
    assign bus.press_count = press_count_q;

endmodule : button_event
`default_nettype wire

// File: doc/button_event.md
Name: button_event

Overview:
- Consumes the debounced level `db` from the debounce stage and turns it into single-cycle user events: press, release, long-press and auto-repeat.
- Also maintains a wrapping press counter.
- Shares the same millisecond `m_tick` strobe that paces the debouncer, so hold timing is in ticks, not clocks.
- Sits between the debouncer and the control/register logic that acts on button events.

Parameters:
- LONG_TICKS, 100, ticks of continuous hold before long_press fires; legal range >= 1.
- REPEAT_TICKS, 20, ticks between repeat pulses once in long-press; 0 disables repeat.
- CNT_W, 8, width of press_count.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- m_tick  input  1  one-clk strobe, period >> 1 clk, synchronous to clk.
- db  input  1  debounced switch level, synchronous to clk.
- clr_count  input  1  synchronous clear of press_count.
- press  output  1  one-clk pulse on db rising.
- release  output  1  one-clk pulse on db falling.
- long_press  output  1  one-clk pulse when hold reaches LONG_TICKS.
- repeat  output  1  one-clk pulse every REPEAT_TICKS while in long hold.
- held  output  1  level, high while the FSM is not in IDLE.
- press_count  output  CNT_W  number of presses, modulo 2^CNT_W.

Behaviour:

Interface and reset:
- One clock `clk`. Reset `reset` is asynchronous and active-high.
- All state is cleared immediately on reset assertion, independent of clk.
- Reset values: state=IDLE, db_q=0, hold_cnt=0, rep_cnt=0, all pulse outputs 0, held=0, press_count=0.
- db_q is a single register of db. rise = db & ~db_q; fall = ~db & db_q.
- All outputs are registered. An event detected at clock edge k is visible during the cycle after edge k, i.e. 1-clk latency from db sampling.
- A db=1 present at reset release yields a press on the first edge. This is accepted; the debouncer also resets db to 0.

FSM states, one-hot encoded:
- IDLE:
  - rise -> SHORT, press<=1, hold_cnt<=0, press_count<=press_count+1 (wraps).
- SHORT:
  - fall -> IDLE, release<=1.
  - else if m_tick and hold_cnt==LONG_TICKS-1 -> LONG, long_press<=1, rep_cnt<=0.
  - else if m_tick -> hold_cnt<=hold_cnt+1.
- LONG:
  - fall -> IDLE, release<=1.
  - else if REPEAT_TICKS!=0 and m_tick and rep_cnt==REPEAT_TICKS-1 -> repeat<=1, rep_cnt<=0.
  - else if m_tick -> rep_cnt<=rep_cnt+1.
- Illegal or non-one-hot state -> IDLE, no pulses.

Outputs and counters:
- held = registered (next_state != IDLE); rises with press and falls with release.
- Each pulse output is high for exactly one cycle. press and release are never high together.
- Counter widths: hold_cnt is $clog2(LONG_TICKS+1) bits; rep_cnt is $clog2(REPEAT_TICKS+1) bits (min 1).
- Counters never exceed their terminal values.

Boundary conditions:
- fall and m_tick on the same edge: fall wins; no long_press or repeat.
- LONG_TICKS=1: long_press fires on the first m_tick after press.
- press_count wraps at 2^CNT_W-1 -> 0.
- clr_count has priority over the increment, except that clr_count and press on the same edge -> press_count=1.
- Reset asserted mid-hold: outputs drop immediately; no release pulse is generated.
- m_tick on the same edge as rise: not counted. hold_cnt starts at 0 on the next edge.

Decomposition:
- Shared package `debounce_pkg` holds:
  - the one-hot state typedef for this block, with bit-index localparams;
  - the common one-hot state-index convention used with the debounce FSM.
- One natural sub-module: `edge_detect`.
  - Inputs: clk, reset, d. Outputs: rise, fall. Holds the db_q register.
  - Reusable by other debounced inputs.
- The FSM and counters remain in button_event.

Test Plan:
Bench settings: LONG_TICKS=4, REPEAT_TICKS=2, CNT_W=2, m_tick every 10 clks.
1. Short press: db high for 25 clks -> press 1 clk after rise; release 1 clk after fall; no long_press; held high for 25 clks; press_count=1.
2. Long hold: db high for 100 clks -> long_press on the 4th m_tick; repeat on the 6th, 8th and 10th m_tick; one release; press_count=1.
3. Collision: assert db fall on the same clk as the 4th m_tick -> release=1, long_press never asserted.
4. Counter wrap and clear: 5 short presses -> press_count 1,2,3,0,1; clr_count with the 6th press on the same edge -> press_count=1.
5. Async reset mid-hold: after long_press, assert reset between clk edges -> all outputs 0 before the next edge; no release; press_count=0.
6. REPEAT_TICKS=0 build: 100-clk hold -> exactly one long_press, zero repeat pulses.
